skein_nonce_scheduler: RTL and testbench

SKEIN_NONCE_SCHEDULER -- requirements
Module: skein_nonce_scheduler

---
 rtl/skein_pkg.sv | 34 +++
 rtl/skein_nonce_scheduler_if.sv | 39 +++
 rtl/skein_tag_delay.sv | 39 +++
 rtl/skein_nonce_scheduler.sv | 131 +++++++++++++
 tb/tb_skein_nonce_scheduler.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/skein_pkg.sv
// Shared types and widths for the skein512 nonce scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package skein_pkg;

  localparam int MIDSTATE_W  = 512;
  localparam int DATA_W      = 96;
  localparam int NONCE_W     = 32;
  localparam int TARGET_W    = 64;
  localparam int HASH_W      = 512;
  localparam int LATENCY_DEF = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Job fields held for the whole job after accept.
  typedef struct packed {
    logic [MIDSTATE_W-1:0] midstate;
    logic [DATA_W-1:0]     data;
    logic [NONCE_W-1:0]    nonce_end;
    logic [TARGET_W-1:0]   target;
  } job_t;

  // Difficulty test: the top 64 hash bits compared unsigned against the target.
  function automatic logic is_hit(input logic [TARGET_W-1:0] hash_top,
                                  input logic [TARGET_W-1:0] target);
    return hash_top <= target;
  endfunction

endpackage

// File: rtl/skein_nonce_scheduler_if.sv
// Job, core and result signals of the nonce scheduler bundled as one port.
// Latency: n/a (wires only).
// Backpressure: job_valid/job_ready and res_valid/res_ready handshakes.
interface skein_nonce_scheduler_if;
  import skein_pkg::*;

  logic                  job_valid;
  logic                  job_ready;
  logic [MIDSTATE_W-1:0] job_midstate;
  logic [DATA_W-1:0]     job_data;
  logic [NONCE_W-1:0]    job_nonce_start;
  logic [NONCE_W-1:0]    job_nonce_end;
  logic [TARGET_W-1:0]   job_target;
  logic                  abort;
  logic [MIDSTATE_W-1:0] midstate;
  logic [DATA_W-1:0]     data;
  logic [NONCE_W-1:0]    nonce;
  logic [HASH_W-1:0]     hash;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_found;
  logic [NONCE_W-1:0]    res_nonce;
  logic                  busy;

  // Scheduler side.
  modport slave (
    input  job_valid, job_midstate, job_data, job_nonce_start, job_nonce_end,
           job_target, abort, hash, res_ready,
    output job_ready, midstate, data, nonce, res_valid, res_found, res_nonce, busy
  );

  // Job source / core / result sink side.
  modport master (
    output job_valid, job_midstate, job_data, job_nonce_start, job_nonce_end,
           job_target, abort, hash, res_ready,
    input  job_ready, midstate, data, nonce, res_valid, res_found, res_nonce, busy
  );

endinterface

// File: rtl/skein_tag_delay.sv
// Tag delay line: issue bit + nonce, aligned with the skein512 core latency.
// Latency: DEPTH cycles from i_* to o_*.
// Backpressure: none; shifts every cycle.
module skein_tag_delay
  import skein_pkg::*;
#(
  parameter int DEPTH = LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vld,
  input  logic [NONCE_W-1:0] i_nonce,
  output logic               o_vld,
  output logic [NONCE_W-1:0] o_nonce
);

  logic [DEPTH-1:0]   r_vld;
  logic [NONCE_W-1:0] r_tag [DEPTH];

  // Valid chain: cleared on reset so nothing stale is ever scored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Nonce tags: meaningless without their valid bit, so no reset needed.
  always_ff @(posedge clk) begin
    r_tag[0] <= i_nonce;
    for (int i = 1; i < DEPTH; i++) r_tag[i] <= r_tag[i-1];
  end

  assign o_vld   = r_vld[DEPTH-1];
  assign o_nonce = r_tag[DEPTH-1];

endmodule

// File: rtl/skein_nonce_scheduler.sv
// Walks a nonce range into a skein512 core and reports the first hash <= target.
// Latency: hit flag captured LATENCY+1 cycles after the nonce is issued.
// Backpressure: job_ready only in IDLE; result held in DONE until res_ready.
module skein_nonce_scheduler
  import skein_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input logic                    clk,
  input logic                    rst,
  skein_nonce_scheduler_if.slave io
);

  // In-flight count never exceeds LATENCY (one per delay-line stage).
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  job_t               r_job;
  logic [NONCE_W-1:0] r_cnt;
  logic               r_found;
  logic               r_aborted;
  logic [NONCE_W-1:0] r_res_nonce;
  logic [CNT_W-1:0]   r_inflight;
  logic [CNT_W-1:0]   w_inflight_nxt;

  logic               w_accept;
  logic               w_issue;
  logic               w_last;
  logic               w_hit;
  logic               w_active;
  logic               w_tag_vld;
  logic [NONCE_W-1:0] w_tag_nonce;
  logic               w_job_ready;
  logic               w_res_valid;
  logic               w_busy;

  skein_tag_delay #(.DEPTH(LATENCY)) u_tag_delay (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (w_issue),
    .i_nonce (r_cnt),
    .o_vld   (w_tag_vld),
    .o_nonce (w_tag_nonce)
  );

  assign w_active       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_accept       = (r_state == ST_IDLE) && io.job_valid;
  // Abort suppresses the issue in its own cycle.
  assign w_issue        = (r_state == ST_RUN) && !io.abort;
  // Equality only: a range with end < start wraps through 0xFFFFFFFF.
  assign w_last         = (r_cnt == r_job.nonce_end);
  // Only the first hit counts; abort in the same cycle discards it.
  assign w_hit          = w_active && w_tag_vld && !r_found && !r_aborted && !io.abort &&
                          is_hit(io.hash[HASH_W-1 -: TARGET_W], r_job.target);
  assign w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_tag_vld);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_job_ready = 1'b0;
    w_res_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_job_ready = 1'b1;
        w_busy      = 1'b0;
        if (io.job_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (io.abort || w_hit || w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_inflight_nxt == '0)
          w_state_nxt = (r_aborted || io.abort) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        w_res_valid = 1'b1;
        if (io.res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Job latch, nonce counter, in-flight count and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_job       <= '0;
      r_cnt       <= '0;
      r_found     <= 1'b0;
      r_aborted   <= 1'b0;
      r_res_nonce <= '0;
      r_inflight  <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_accept) begin
        r_job <= '{midstate:  io.job_midstate,
                   data:      io.job_data,
                   nonce_end: io.job_nonce_end,
                   target:    io.job_target};
        r_cnt       <= io.job_nonce_start;
        r_found     <= 1'b0;
        r_aborted   <= 1'b0;
        r_res_nonce <= '0;
      end else begin
        if (w_issue) r_cnt <= r_cnt + NONCE_W'(1);
        if (w_hit) begin
          r_found     <= 1'b1;
          r_res_nonce <= w_tag_nonce;
        end
        if (io.abort && w_active) r_aborted <= 1'b1;
      end
    end
  end

  assign io.job_ready = w_job_ready;
  assign io.res_valid = w_res_valid;
  assign io.busy      = w_busy;
  assign io.midstate  = r_job.midstate;
  assign io.data      = r_job.data;
  assign io.nonce     = r_cnt;
  assign io.res_found = r_found;
  assign io.res_nonce = r_res_nonce;

endmodule

// File: tb/tb_skein_nonce_scheduler.sv
// Bench for skein_nonce_scheduler: table-driven jobs plus abort/reset/DONE-hold sequences.
module tb_skein_nonce_scheduler;
  import skein_pkg::*;

  localparam int LAT = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  skein_nonce_scheduler_if bus();

  skein_nonce_scheduler #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // Core model: LAT-cycle delay of the presented nonce, then a simple hash.
  // m_rev=0: top = nonce + m_k; m_rev=1: top = m_k[31:0] - nonce (descending).
  logic [31:0] core_pipe [LAT];
  logic        m_rev = 1'b0;
  logic [63:0] m_k   = 64'd0;

  always @(posedge clk) begin
    core_pipe[0] <= bus.nonce;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end

  assign bus.hash = {(m_rev ? {32'h0, m_k[31:0] - core_pipe[LAT-1]}
                            : ({32'h0, core_pipe[LAT-1]} + m_k)), 448'h0};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue monitor: every issued nonce must follow the previous one mod 2^32.
  logic        mon_en = 1'b0;
  logic [31:0] mon_next;
  int          mon_issues;

  always @(negedge clk) begin
    if (mon_en && dut.w_issue) begin
      check("issue_nonce", {480'h0, bus.nonce}, {480'h0, mon_next});
      mon_next   = mon_next + 32'd1;
      mon_issues = mon_issues + 1;
    end
  end

  typedef struct {
    logic [31:0] start;
    logic [31:0] stop;
    logic [63:0] target;
    logic        rev;
    logic [63:0] k;
    logic        exp_found;
    logic [31:0] exp_nonce;
    int          exp_issues;
  } vec_t;

  typedef struct {
    logic        found;
    logic [31:0] nonce;
  } res_t;

  vec_t vecs[5];
  res_t sb[$];

  task automatic drive_job(input logic [31:0] start, input logic [31:0] stop,
                           input logic [63:0] target, input logic rev, input logic [63:0] k);
    m_rev               = rev;
    m_k                 = k;
    bus.job_midstate    = {16{start}};
    bus.job_data        = {3{stop}};
    bus.job_nonce_start = start;
    bus.job_nonce_end   = stop;
    bus.job_target      = target;
    bus.job_valid       = 1'b1;
    @(posedge clk); #1;
    bus.job_valid       = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_job_ready", bus.job_ready, 0);
    check("midstate_latched", bus.midstate, {16{start}});
    check("data_latched", bus.data, {3{stop}});
    mon_next   = start;
    mon_issues = 0;
    mon_en     = 1'b1;
  endtask

  // Returns cycles from job accept until res_valid (or the bound).
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.res_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    mon_en = 1'b0;
    check("res_valid_seen", bus.res_valid, 1);
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("post_hs_busy", bus.busy, 0);
    check("post_hs_job_ready", bus.job_ready, 1);
    check("post_hs_res_valid", bus.res_valid, 0);
  endtask

  task automatic run_job(input vec_t v);
    int   cyc;
    res_t e;
    drive_job(v.start, v.stop, v.target, v.rev, v.k);
    sb.push_back('{v.exp_found, v.exp_nonce});
    wait_result(cyc);
    e = sb.pop_front();
    check("res_found", bus.res_found, e.found);
    check("res_nonce", bus.res_nonce, e.nonce);
    check("issue_count", mon_issues, v.exp_issues);
    // Last issue at index issues-1, its tag surfaces LAT later, DONE the cycle after.
    check("result_latency", cyc, v.exp_issues + LAT);
    handshake();
  endtask

  task automatic run_abort(input logic [31:0] start, input logic [31:0] stop,
                           input logic [63:0] target, input logic rev, input logic [63:0] k,
                           input int ab_idx, input int exp_issues);
    int cyc;
    int seen_valid;
    drive_job(start, stop, target, rev, k);
    for (int i = 0; i < ab_idx; i++) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort  = 1'b0;
    cyc        = 1;
    seen_valid = 0;
    while (bus.busy && cyc < LAT + 10) begin
      if (bus.res_valid) seen_valid++;
      @(posedge clk); #1;
      cyc++;
    end
    mon_en = 1'b0;
    check("abort_drain_bound", (cyc <= LAT + 2), 1);
    check("abort_no_res_valid", seen_valid, 0);
    check("abort_idle_busy", bus.busy, 0);
    check("abort_job_ready", bus.job_ready, 1);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_found_clear", bus.res_found, 0);
    check("abort_issue_count", mon_issues, exp_issues);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_job_ready"}, bus.job_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_found"}, bus.res_found, 0);
    check({tag, "_res_nonce"}, bus.res_nonce, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_nonce"}, bus.nonce, 0);
    check({tag, "_midstate"}, bus.midstate, 0);
    check({tag, "_data"}, bus.data, 0);
  endtask

  initial begin
    int cyc;
    int seen;
    res_t e;

    //            start          stop       target  rev   k        found nonce  issues
    // Descending hash so the first nonce at or below 50 is exactly 50.
    vecs[0] = '{32'd0,         32'd99,    64'd50, 1'b1, 64'd100,  1'b1, 32'd50, 100};
    // Offset model: nothing reaches target 0.
    vecs[1] = '{32'd10,        32'd19,    64'd0,  1'b0, 64'd1000, 1'b0, 32'd0,  10};
    // Wrap FFFFFFFE, FFFFFFFF, 0, 1.
    vecs[2] = '{32'hFFFF_FFFE, 32'h1,     64'd0,  1'b0, 64'd1,    1'b0, 32'd0,  4};
    // Nonce 0 hits in the same cycle nonce 80 (the last) is presented: hit wins.
    vecs[3] = '{32'd0,         32'd80,    64'd0,  1'b0, 64'd0,    1'b1, 32'd0,  81};
    // Nonce 0 hits mid-RUN: issuing stops after nonce 80.
    vecs[4] = '{32'd0,         32'd99,    64'd0,  1'b0, 64'd0,    1'b1, 32'd0,  81};

    bus.job_valid       = 1'b0;
    bus.job_midstate    = '0;
    bus.job_data        = '0;
    bus.job_nonce_start = '0;
    bus.job_nonce_end   = '0;
    bus.job_target      = '0;
    bus.abort           = 1'b0;
    bus.res_ready       = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // Abort five cycles into RUN with no hit pending.
    run_abort(32'd0, 32'd999, 64'd0, 1'b0, 64'd1000, 5, 5);
    // Abort lands in the same cycle as the nonce-0 hit: abort wins.
    run_abort(32'd0, 32'd999, 64'd0, 1'b0, 64'd0, LAT, LAT);

    // Reset pulsed in DRAIN discards the job.
    drive_job(32'd0, 32'd9, 64'd0, 1'b0, 64'd1000);
    repeat (20) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("drain_before_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("rst_in_drain");
    seen = 0;
    for (int i = 0; i < LAT + 40; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.busy) seen++;
    end
    check("rst_discard_quiet", seen, 0);
    run_job(vecs[0]);

    // DONE held for 20 cycles with a competing job offered.
    drive_job(32'd0, 32'd9, 64'd3, 1'b0, 64'd0);
    sb.push_back('{1'b1, 32'd0});
    wait_result(cyc);
    check("hold_latency", cyc, 10 + LAT);
    e = sb.pop_front();
    bus.job_valid       = 1'b1;
    bus.job_nonce_start = 32'd500;
    bus.job_nonce_end   = 32'd600;
    for (int i = 0; i < 20; i++) begin
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_res_found", bus.res_found, e.found);
      check("hold_res_nonce", bus.res_nonce, e.nonce);
      check("hold_job_ready", bus.job_ready, 0);
      @(posedge clk); #1;
    end
    bus.job_valid = 1'b0;
    check("hold_still_busy", bus.busy, 1);
    check("hold_midstate_kept", bus.midstate, {16{32'd0}});
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
